// File: rtl/rf_mode_sequencer.sv
// Operating-mode sequencer: synchronises and debounces the mode pins, applies a new
// mode only while the radio core and UART are idle, and holds AUX low while it settles.
module rf_mode_sequencer #(
   parameter int   MODE_W        = 2,
   parameter int   DEFAULT_MODE  = 3,
   parameter int   SLEEP_MODE    = 3,
   parameter int   SYNC_STAGES   = 2,
   parameter int   STABLE_CYCLES = 4,
   parameter int   T_POWER_ON    = 750000,
   parameter int   T_WAKE        = 10000,
   parameter int   T_SWITCH      = 64,
   parameter logic AUX_POWER_ON  = 1'b0,
   parameter int   CNT_W         = 20
) (
   input  logic              internal_clk,
   input  logic              rst_n,
   input  logic [MODE_W-1:0] mode_req,
   input  logic              aux_state,
   input  logic              aux_uart,
   output logic [MODE_W-1:0] mode_cur,
   output logic              aux_out,
   output logic              busy,
   output logic              mode_done,
   output logic [7:0]        switch_cnt,
   output logic [1:0]        fsm_state
);

   localparam int STB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [STB_W-1:0]  STB_MAX   = STB_W'(STABLE_CYCLES - 1);
   localparam logic [MODE_W-1:0] DEF_MODE  = MODE_W'(DEFAULT_MODE);
   localparam logic [MODE_W-1:0] SLP_MODE  = MODE_W'(SLEEP_MODE);
   localparam logic [CNT_W-1:0]  LD_POWER  = CNT_W'(T_POWER_ON - 1);
   localparam logic [CNT_W-1:0]  LD_WAKE   = CNT_W'(T_WAKE - 1);
   localparam logic [CNT_W-1:0]  LD_SWITCH = CNT_W'(T_SWITCH - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SWITCH = 2'd1,
      ST_INIT   = 2'd2
   } state_t;

   logic [MODE_W-1:0] r_sync [SYNC_STAGES];
   logic [MODE_W-1:0] r_cand;
   logic [MODE_W-1:0] r_accepted;
   logic [STB_W-1:0]  r_stab_cnt;
   logic [MODE_W-1:0] w_sync_out;

   state_t            r_state,      w_state_nxt;
   logic [CNT_W-1:0]  r_timer,      w_timer_nxt;
   logic [MODE_W-1:0] r_mode_cur,   w_mode_nxt;
   logic              r_aux,        w_aux_nxt;
   logic              r_busy,       w_busy_nxt;
   logic              r_done,       w_done_nxt;
   logic [7:0]        r_switch_cnt, w_cnt_nxt;
   logic              w_free;

   assign w_sync_out = r_sync[SYNC_STAGES-1];
   assign w_free     = aux_state & aux_uart;

   // Synchroniser and debounce run in every state, preloaded so reset causes no switch.
   always_ff @(posedge internal_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= DEF_MODE;
         r_cand     <= DEF_MODE;
         r_accepted <= DEF_MODE;
         r_stab_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would collapse the sync chain.
         r_sync[0] <= mode_req;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         if (w_sync_out != r_cand) begin
            r_cand     <= w_sync_out;
            r_stab_cnt <= '0;
         end else begin
            if (r_stab_cnt != STB_MAX) r_stab_cnt <= r_stab_cnt + STB_W'(1);
            if (r_stab_cnt == STB_MAX) r_accepted <= r_cand;
         end
      end
   end

   always_ff @(posedge internal_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_INIT;
         r_timer      <= LD_POWER;
         r_mode_cur   <= DEF_MODE;
         r_aux        <= AUX_POWER_ON;
         r_busy       <= 1'b1;
         r_done       <= 1'b0;
         r_switch_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_timer      <= w_timer_nxt;
         r_mode_cur   <= w_mode_nxt;
         r_aux        <= w_aux_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_switch_cnt <= w_cnt_nxt;
      end
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_mode_nxt  = r_mode_cur;
      w_aux_nxt   = r_aux;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_cnt_nxt   = r_switch_cnt;
      unique case (r_state)
         ST_INIT: begin
            w_aux_nxt = AUX_POWER_ON;
            if (r_timer == '0) begin
               w_state_nxt = ST_IDLE;
               w_aux_nxt   = 1'b1;
               w_busy_nxt  = 1'b0;
            end else begin
               w_timer_nxt = r_timer - CNT_W'(1);
            end
         end
         ST_IDLE: begin
            w_aux_nxt  = w_free;
            w_busy_nxt = 1'b0;
            // Aux inputs gate the switch combinationally; a pending request simply waits.
            if ((r_accepted != r_mode_cur) && w_free) begin
               w_state_nxt = ST_SWITCH;
               w_mode_nxt  = r_accepted;
               w_aux_nxt   = 1'b0;
               w_busy_nxt  = 1'b1;
               w_timer_nxt = (r_mode_cur == SLP_MODE) ? LD_WAKE : LD_SWITCH;
               if (r_switch_cnt != 8'hFF) w_cnt_nxt = r_switch_cnt + 8'd1;
            end
         end
         ST_SWITCH: begin
            w_aux_nxt  = 1'b0;
            w_busy_nxt = 1'b1;
            if (r_timer == '0) begin
               w_state_nxt = ST_IDLE;
               w_aux_nxt   = 1'b1;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end else begin
               w_timer_nxt = r_timer - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
            w_timer_nxt = LD_POWER;
         end
      endcase
   end

   assign mode_cur   = r_mode_cur;
   assign aux_out    = r_aux;
   assign busy       = r_busy;
   assign mode_done  = r_done;
   assign switch_cnt = r_switch_cnt;
   assign fsm_state  = r_state;

endmodule

// File: doc/rf_mode_sequencer.md
# rf_mode_sequencer

Parametrised operating-mode sequencer for the RF transceiver. It synchronises and debounces a MODE_W-bit mode request from the MCU pins. It applies the request only when the radio core and UART path report idle, and holds the module-ready (AUX) indication low for a per-transition settling time: power-on, wake from sleep, or ordinary switch. It sits between the external M-pins and the transceiver datapath. It replaces the fixed 2-bit, two-timer controller with configurable width, debounce, distinct wake/switch timing and status outputs.

## Interface
- MODE_W, 2: width of the mode request and applied mode.
- DEFAULT_MODE, 3: mode applied at reset and preloaded into the synchroniser.
- SLEEP_MODE, 3: mode code of stand-by/sleep.
- SYNC_STAGES, 2: synchroniser flops on mode_req (≥2).
- STABLE_CYCLES, 4: cycles the synchronised request must hold before acceptance (≥1).
- T_POWER_ON, 750000: INIT duration in cycles (≥1).
- T_WAKE, 10000: settle cycles when leaving SLEEP_MODE (≥1).
- T_SWITCH, 64: settle cycles for any other change, including entering SLEEP_MODE (≥1).
- AUX_POWER_ON, 0: aux_out level during INIT.
- CNT_W, 20: timer width; must hold max(T_*)−1.

Ports:
- internal_clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- mode_req  in  MODE_W  raw mode pins (asynchronous).
- aux_state  in  1  radio core idle (1 = free).
- aux_uart  in  1  UART path idle (1 = free).
- mode_cur  out  MODE_W  applied mode.
- aux_out  out  1  module-ready indication.
- busy  out  1  high in INIT and SWITCH.
- mode_done  out  1  one-cycle pulse when a switch settles.
- switch_cnt  out  8  saturating count of applied switches.
- fsm_state  out  2  INIT=2, IDLE=0, SWITCH=1.

## Operation
- Reset values:
  - mode_cur=DEFAULT_MODE, aux_out=AUX_POWER_ON, busy=1, mode_done=0, switch_cnt=0, fsm_state=INIT.
  - Timer = T_POWER_ON−1. Synchroniser, candidate and accepted request = DEFAULT_MODE. Stability counter = 0.
- Synchroniser: SYNC_STAGES-flop shift chain on mode_req.
- Debounce:
  - If sync output ≠ candidate: candidate ← sync, counter ← 0.
  - Otherwise the counter increments, saturating at STABLE_CYCLES−1.
  - If the counter already equals STABLE_CYCLES−1, accepted ← candidate.
  - Debounce runs in every state.
- INIT:
  - aux_out=AUX_POWER_ON. Timer decrements each cycle.
  - On the edge where the timer is 0: go to IDLE, aux_out←1, busy←0.
- IDLE:
  - aux_out ← aux_state & aux_uart, registered.
  - If accepted ≠ mode_cur and aux_state & aux_uart = 1: mode_cur ← accepted, go to SWITCH, aux_out←0, busy←1, switch_cnt increments (saturates at 255).
  - Timer load: T_WAKE−1 if the old mode_cur = SLEEP_MODE, else T_SWITCH−1.
  - If either aux input is 0, the request waits; no timeout.
- SWITCH:
  - Timer decrements. aux_out=0, busy=1.
  - On the edge where the timer is 0: go to IDLE, aux_out←1, busy←0, mode_done←1 for one cycle.
  - Requests accepted during SWITCH are not applied. They are re-evaluated in the first IDLE cycle, giving back-to-back switches with one IDLE cycle between them.
  - A request returning to mode_cur during SWITCH causes no further switch.
- rst_n assertion in any state returns to reset values immediately. A switch in progress is abandoned.

## Timing
- mode_req change → accepted: SYNC_STAGES+STABLE_CYCLES+1 edges.
- accepted → mode_cur in IDLE with both aux inputs high: +1 edge.
- Defaults: mode_cur updates on the 8th edge after the mode_req change.
- Pulses on the sync output shorter than STABLE_CYCLES cycles never reach accepted.
- INIT lasts exactly T_POWER_ON cycles after rst_n deassertion. aux_out rises on edge T_POWER_ON.
- SWITCH lasts exactly T (T_WAKE or T_SWITCH) cycles. aux_out low and busy high for T cycles.
- mode_done is high in the first IDLE cycle after SWITCH.
- aux_state/aux_uart have one-cycle latency to aux_out in IDLE. They are sampled combinationally for the switch decision.
- Simultaneous accepted change and aux input drop in the same cycle: no switch; retried when both inputs are high.

## Test plan
Bench parameters: SYNC_STAGES=2, STABLE_CYCLES=4, T_POWER_ON=20, T_WAKE=10, T_SWITCH=3.

- Reset then idle, aux inputs high → aux_out=0 for 20 cycles, then 1; busy falls at the same edge; mode_cur=3 throughout.
- After INIT, mode_req 3→0 → mode_cur=0 on the 8th edge; aux_out low 10 cycles; mode_done pulses once; switch_cnt=1.
- In mode 0, mode_req 0→1 → aux_out low 3 cycles. Then mode_req 1→3 → aux_out low 3 cycles. switch_cnt=3.
- 3-cycle glitch on mode_req (0→2→0) → mode_cur stays 0, no mode_done, aux_out stays 1.
- Request 1 with aux_uart=0 for 50 cycles → mode_cur unchanged, busy=0. Raising aux_uart → switch on the next edge.
- rst_n pulse mid-SWITCH → all outputs at reset values; INIT restarts and lasts the full 20 cycles.
